// File: rtl/mmu_pkg.sv
// Shared widths, result-select codes, sequencing constants and the result
// saturation helper for the 2x2 systolic matrix-multiply unit.
package mmu_pkg;

   localparam int DATA_W    = 8;
   localparam int ACC_W     = 16;
   localparam int ACC_INT_W = 2 * DATA_W + 1;

   localparam logic [1:0] OSEL_C00 = 2'd0;
   localparam logic [1:0] OSEL_C01 = 2'd1;
   localparam logic [1:0] OSEL_C10 = 2'd2;
   localparam logic [1:0] OSEL_C11 = 2'd3;

   localparam logic [2:0] MMU_FIRST_STEP = 3'd0;
   localparam logic [2:0] MMU_LAST_STEP  = 3'd3;

   // Clamp a full-precision partial sum into the narrower signed result range.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_INT_W-1:0] v);
      logic signed [ACC_INT_W-1:0] max_v;
      logic signed [ACC_INT_W-1:0] min_v;
      logic signed [ACC_W-1:0]     r;
      max_v = {{(ACC_INT_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
      min_v = {{(ACC_INT_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};
      if (v > max_v) begin
         r = {1'b0, {(ACC_W - 1){1'b1}}};
      end else if (v < min_v) begin
         r = {1'b1, {(ACC_W - 1){1'b0}}};
      end else begin
         r = v[ACC_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/mmu_pe.sv
// Output-stationary MAC processing element: forwards its operands one step
// right/down and either loads or accumulates their signed product.
module mmu_pe #(
   parameter int DATA_W = mmu_pkg::DATA_W,
   parameter int PSUM_W = 2 * DATA_W + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     step,
   input  logic                     load,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic signed [DATA_W-1:0] b_in,
   output logic signed [DATA_W-1:0] a_out,
   output logic signed [DATA_W-1:0] b_out,
   output logic signed [PSUM_W-1:0] acc
);

   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [PSUM_W-1:0]   prod_ext_s;
   logic signed [PSUM_W-1:0]   acc_nxt_s;
   logic signed [DATA_W-1:0]   a_r;
   logic signed [DATA_W-1:0]   b_r;
   logic signed [PSUM_W-1:0]   acc_r;

   // Product of the current operands and the resulting accumulator value.
   always_comb begin
      prod_s     = a_in * b_in;
      prod_ext_s = PSUM_W'(prod_s);
      if (load) begin
         acc_nxt_s = prod_ext_s;
      end else begin
         acc_nxt_s = acc_r + prod_ext_s;
      end
   end

   // Operand forwarding and accumulation; everything freezes between steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= {DATA_W{1'b0}};
         b_r   <= {DATA_W{1'b0}};
         acc_r <= {PSUM_W{1'b0}};
      end else if (step) begin
         a_r   <= a_in;
         b_r   <= b_in;
         acc_r <= acc_nxt_s;
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         acc_r <= acc_r;
      end
   end

   assign a_out = a_r;
   assign b_out = b_r;
   assign acc   = acc_r;

endmodule

// File: rtl/mmu_systolic_2x2.sv
// 2x2 output-stationary systolic matrix multiply (C = A x B) with skewed
// edge feeds, completion flags and a saturated, selectable result port.
module mmu_systolic_2x2 #(
   parameter int DATA_W = mmu_pkg::DATA_W,
   parameter int ACC_W  = mmu_pkg::ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mmu_en,
   input  logic [2:0]               mmu_cycle,
   input  logic [4*DATA_W-1:0]      mat_a,
   input  logic [4*DATA_W-1:0]      mat_b,
   input  logic [1:0]               output_select,
   output logic signed [ACC_W-1:0]  c_out,
   output logic                     c_valid,
   output logic                     busy
);

   import mmu_pkg::*;

   localparam int PSUM_W = 2 * DATA_W + 1;

   logic                     step_s;
   logic                     start_s;
   logic                     last_s;
   logic signed [DATA_W-1:0] row_a_s [2];
   logic signed [DATA_W-1:0] col_b_s [2];
   logic signed [DATA_W-1:0] a_in_s  [2][2];
   logic signed [DATA_W-1:0] b_in_s  [2][2];
   logic signed [DATA_W-1:0] a_fwd_s [2][2];
   logic signed [DATA_W-1:0] b_fwd_s [2][2];
   logic signed [PSUM_W-1:0] acc_s   [2][2];
   logic signed [PSUM_W-1:0] sel_acc_s;
   logic                     c_valid_r;
   logic                     busy_r;
   logic                     unused_edge_fwd_s;

   assign step_s  = mmu_en & (mmu_cycle <= MMU_LAST_STEP);
   assign start_s = step_s & (mmu_cycle == MMU_FIRST_STEP);
   assign last_s  = step_s & (mmu_cycle == MMU_LAST_STEP);

   // Skewed edge feeds: row i / column j see their k-th operand on step i+k / j+k.
   always_comb begin
      row_a_s[0] = {DATA_W{1'b0}};
      row_a_s[1] = {DATA_W{1'b0}};
      col_b_s[0] = {DATA_W{1'b0}};
      col_b_s[1] = {DATA_W{1'b0}};
      case (mmu_cycle)
         3'd0: begin
            row_a_s[0] = mat_a[DATA_W-1:0];
            col_b_s[0] = mat_b[DATA_W-1:0];
         end
         3'd1: begin
            row_a_s[0] = mat_a[2*DATA_W-1:DATA_W];
            row_a_s[1] = mat_a[3*DATA_W-1:2*DATA_W];
            col_b_s[0] = mat_b[3*DATA_W-1:2*DATA_W];
            col_b_s[1] = mat_b[2*DATA_W-1:DATA_W];
         end
         3'd2: begin
            row_a_s[1] = mat_a[4*DATA_W-1:3*DATA_W];
            col_b_s[1] = mat_b[4*DATA_W-1:3*DATA_W];
         end
         default: begin
            row_a_s[0] = {DATA_W{1'b0}};
            row_a_s[1] = {DATA_W{1'b0}};
            col_b_s[0] = {DATA_W{1'b0}};
            col_b_s[1] = {DATA_W{1'b0}};
         end
      endcase
   end

   for (genvar i = 0; i < 2; i++) begin : g_row
      for (genvar j = 0; j < 2; j++) begin : g_col
         // Interior links are forced to zero on a start so stale operands
         // from an aborted run never reach the freshly loaded accumulators.
         if (j == 0) begin : g_a_edge
            assign a_in_s[i][j] = row_a_s[i];
         end else begin : g_a_link
            assign a_in_s[i][j] = start_s ? {DATA_W{1'b0}} : a_fwd_s[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign b_in_s[i][j] = col_b_s[j];
         end else begin : g_b_link
            assign b_in_s[i][j] = start_s ? {DATA_W{1'b0}} : b_fwd_s[i-1][j];
         end

         mmu_pe #(
            .DATA_W (DATA_W),
            .PSUM_W (PSUM_W)
         ) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .step  (step_s),
            .load  (start_s),
            .a_in  (a_in_s[i][j]),
            .b_in  (b_in_s[i][j]),
            .a_out (a_fwd_s[i][j]),
            .b_out (b_fwd_s[i][j]),
            .acc   (acc_s[i][j])
         );
      end
   end

   // Operands leaving the right and bottom edges of the array go nowhere.
   assign unused_edge_fwd_s = ^{a_fwd_s[0][1], a_fwd_s[1][1], b_fwd_s[1][0], b_fwd_s[1][1]};

   // Sequence status: a start clears valid, the last step publishes results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_valid_r <= 1'b0;
         busy_r    <= 1'b0;
      end else if (start_s) begin
         c_valid_r <= 1'b0;
         busy_r    <= 1'b1;
      end else if (last_s) begin
         c_valid_r <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         c_valid_r <= c_valid_r;
         busy_r    <= busy_r;
      end
   end

   // Result pick from the registered accumulators.
   always_comb begin
      sel_acc_s = acc_s[0][0];
      case (output_select)
         OSEL_C00: sel_acc_s = acc_s[0][0];
         OSEL_C01: sel_acc_s = acc_s[0][1];
         OSEL_C10: sel_acc_s = acc_s[1][0];
         OSEL_C11: sel_acc_s = acc_s[1][1];
         default:  sel_acc_s = acc_s[0][0];
      endcase
   end

   assign c_out   = sat_acc(sel_acc_s);
   assign c_valid = c_valid_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_mmu_systolic_2x2.sv
// Self-checking bench for mmu_systolic_2x2: directed scenarios plus random
// matrices with random stalls, checked against a plain matrix-product model.
module tb_mmu_systolic_2x2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               mmu_en = 1'b0;
   logic [2:0]         mmu_cycle = 3'd0;
   logic [31:0]        mat_a = 32'd0;
   logic [31:0]        mat_b = 32'd0;
   logic [1:0]         output_select = 2'd0;
   logic signed [15:0] c_out;
   logic               c_valid;
   logic               busy;

   int vectors = 0;
   int miscompares = 0;
   int ma [4];
   int mb [4];

   always #5 clk = ~clk;

   mmu_systolic_2x2 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mmu_en        (mmu_en),
      .mmu_cycle     (mmu_cycle),
      .mat_a         (mat_a),
      .mat_b         (mat_b),
      .output_select (output_select),
      .c_out         (c_out),
      .c_valid       (c_valid),
      .busy          (busy)
   );

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j], clamped to 16-bit signed.
   function automatic int ref_c(input int sel);
      int i;
      int j;
      int s;
      i = sel / 2;
      j = sel % 2;
      s = ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j];
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic set_mats(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
      ma[0] = a0; ma[1] = a1; ma[2] = a2; ma[3] = a3;
      mb[0] = b0; mb[1] = b1; mb[2] = b2; mb[3] = b3;
      mat_a = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
      mat_b = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
   endtask

   task automatic drive(input logic en, input logic [2:0] cyc);
      mmu_en    = en;
      mmu_cycle = cyc;
      @(posedge clk);
      #1;
      mmu_en = 1'b0;
   endtask

   task automatic run_full();
      for (int c = 0; c < 7; c++) drive(1'b1, 3'(c));
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (c_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got valid=%0b busy=%0b expected 0 0", c_valid, busy);
      end
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_c_out[%0d]: got %0d expected 0", s, c_out);
         end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int exp_v [4] = '{19, 22, 43, 50};
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, 3'(c));
         vectors++;
         if (c_valid !== (c >= 3) || busy !== (c < 3)) begin
            miscompares++;
            $display("FAIL basic_flags@%0d: got valid=%0b busy=%0b expected %0b %0b",
                     c, c_valid, busy, c >= 3, c < 3);
         end
      end
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'(exp_v[s]) || c_out !== 16'(ref_c(s))) begin
            miscompares++;
            $display("FAIL basic_c[%0d]: got %0d expected %0d", s, c_out, exp_v[s]);
         end
      end
   endtask

   task automatic test_saturation();
      set_mats(-128, -128, -128, -128, -128, -128, -128, -128);
      run_full();
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'sd32767) begin
            miscompares++;
            $display("FAIL sat_pos[%0d]: got %0d expected 32767", s, c_out);
         end
      end
      set_mats(-128, -128, -128, -128, 127, 127, 127, 127);
      run_full();
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== -16'sd32512) begin
            miscompares++;
            $display("FAIL sat_neg[%0d]: got %0d expected -32512", s, c_out);
         end
      end
   endtask

   task automatic test_stall();
      int exp_v [4] = '{19, 22, 43, 50};
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      drive(1'b1, 3'd0);
      drive(1'b1, 3'd1);
      for (int g = 0; g < 3; g++) begin
         drive(1'b0, 3'(g + 2));
         vectors++;
         if (busy !== 1'b1 || c_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_flags@%0d: got busy=%0b valid=%0b expected 1 0", g, busy, c_valid);
         end
      end
      for (int c = 2; c < 7; c++) drive(1'b1, 3'(c));
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'(exp_v[s])) begin
            miscompares++;
            $display("FAIL stall_c[%0d]: got %0d expected %0d", s, c_out, exp_v[s]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_v [4] = '{9, -1, 2, 3};
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      run_full();
      set_mats(1, 0, 0, 1, 9, -1, 2, 3);
      drive(1'b1, 3'd0);
      vectors++;
      if (c_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_flags: got valid=%0b busy=%0b expected 0 1", c_valid, busy);
      end
      for (int c = 1; c < 7; c++) drive(1'b1, 3'(c));
      vectors++;
      if (c_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_valid: got %0b expected 1", c_valid);
      end
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'(exp_v[s])) begin
            miscompares++;
            $display("FAIL restart_c[%0d]: got %0d expected %0d", s, c_out, exp_v[s]);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      drive(1'b1, 3'd0);
      drive(1'b1, 3'd1);
      output_select = 2'd0;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (c_valid !== 1'b0 || busy !== 1'b0 || c_out !== 16'sd0) begin
         miscompares++;
         $display("FAIL mid_reset: got valid=%0b busy=%0b c=%0d expected 0 0 0", c_valid, busy, c_out);
      end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_full();
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'(ref_c(s))) begin
            miscompares++;
            $display("FAIL after_reset_c[%0d]: got %0d expected %0d", s, c_out, ref_c(s));
         end
      end
   endtask

   task automatic test_ignored_cycles();
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      run_full();
      for (int c = 4; c < 8; c++) drive(1'b1, 3'(c));
      vectors++;
      if (c_valid !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignored_flags: got valid=%0b busy=%0b expected 1 0", c_valid, busy);
      end
      for (int s = 0; s < 4; s++) begin
         output_select = 2'(s);
         #1;
         vectors++;
         if (c_out !== 16'(ref_c(s))) begin
            miscompares++;
            $display("FAIL ignored_c[%0d]: got %0d expected %0d", s, c_out, ref_c(s));
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         set_mats(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
         for (int c = 0; c < 7; c++) begin
            if (c >= 1 && c <= 3 && $urandom_range(1) == 1) begin
               for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                  if ($urandom_range(1) == 1) drive(1'b0, 3'($urandom_range(7)));
                  else drive(1'b1, 3'($urandom_range(4, 7)));
               end
            end
            drive(1'b1, 3'(c));
            if (c == 1) begin
               output_select = 2'd0;
               #1;
               vectors++;
               if (c_out !== 16'(ref_c(0)) || busy !== 1'b1 || c_valid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL rand_c00_early #%0d: got c=%0d busy=%0b valid=%0b expected %0d 1 0",
                           n, c_out, busy, c_valid, ref_c(0));
               end
            end
         end
         vectors++;
         if (c_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_flags #%0d: got valid=%0b busy=%0b expected 1 0", n, c_valid, busy);
         end
         for (int s = 0; s < 4; s++) begin
            output_select = 2'(s);
            #1;
            vectors++;
            if (c_out !== 16'(ref_c(s))) begin
               miscompares++;
               $display("FAIL rand_c[%0d] #%0d: got %0d expected %0d", s, n, c_out, ref_c(s));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_ignored_cycles();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mmu_systolic_2x2.md
Name: mmu_systolic_2x2

Overview:
2x2 output-stationary systolic matrix-multiply unit, directly downstream of the control unit and the operand memory. It consumes mmu_en/mmu_cycle from the control unit and the 4+4 signed bytes held in operand memory, and computes C = A x B. It presents one selected result element (picked by output_select) and a results-valid flag to the chip output mux. It contains four MAC processing elements and the skew logic that feeds them.

Parameters:
DATA_W, 8, width of each signed operand element
ACC_W, 16, width of each signed result element on c_out (saturated)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
mmu_en  input  1  compute enable from control unit
mmu_cycle  input  3  compute step index from control unit
mat_a  input  4*DATA_W  weights, packed a00 [7:0], a01 [15:8], a10 [23:16], a11 [31:24]
mat_b  input  4*DATA_W  inputs, packed b00, b01, b10, b11 in the same order
output_select  input  2  result pick: 0=c00, 1=c01, 2=c10, 3=c11
c_out  output  ACC_W  selected result, signed, saturated
c_valid  output  1  all four results final
busy  output  1  computation in progress

Behaviour:
- Reset (rst_n low, any time, including mid-compute): all PE accumulators, skew registers, c_valid and busy go to 0 asynchronously. c_out reads 0.
- A step occurs on a rising edge with mmu_en=1 and mmu_cycle in 0..3. Edges with mmu_en=0, or with mmu_cycle 4..7, freeze all state. The control unit issues cycles 0..6, so 4..6 are ignored.
- Start: a step with mmu_cycle=0. On that edge every PE loads its product (it does not add), c_valid clears and busy sets. This also aborts and restarts any partial computation.
- Edge feeds (left into row i, top into column j; 0 when not listed):
  - Row0: a00 @0, a01 @1.
  - Row1: a10 @1, a11 @2.
  - Col0: b00 @0, b10 @1.
  - Col1: b01 @1, b11 @2.
- PE(i,j) forwards its a input right and its b input down through 1-cycle registers, and accumulates acc += a*b with a signed DATA_W x DATA_W product.
- Accumulator width is 2*DATA_W+1 (17 bits), so there is no internal overflow.
- Result timing, counted in cycles after the start edge:
  - c00 final after step 1.
  - c01 and c10 final after step 2.
  - c11 final after step 3.
- On the mmu_cycle=3 step edge: c_valid goes 1 and busy goes 0. c_valid holds until the next start or reset.
- c_out is combinational from output_select and the registered accumulators. The selected accumulator saturates to ACC_W signed, e.g. +32768 gives 32767 and values below -32768 give -32768.
- c_out reflects partial sums while busy. Consumers sample it only when c_valid=1.
- A gap with mmu_en low mid-sequence stalls the computation. Resuming at the same mmu_cycle gives the correct result.
- mat_a and mat_b must be stable during steps 0..2. They are not registered by this block.

Decomposition:
- Shared package mmu_pkg holds:
  - DATA_W and ACC_W defaults.
  - Localparams OSEL_C00..OSEL_C11 (0..3).
  - Localparam MMU_LAST_STEP = 3.
  - A saturation function.
- One sub-module, mmu_pe: a MAC with a_in/b_in, registered a_out/b_out, and a load/accumulate control.
- It is instantiated 4 times in a 2x2 generate block.

Test Plan:
1. A=[1,2;3,4], B=[5,6;7,8], mmu_en with cycles 0..6 -> c_valid rises after the cycle-3 edge; selects 0..3 give 19, 22, 43, 50.
2. All elements -128, full sequence -> every c_out = 32767 (saturated). Then A all -128, B all 127 -> every c_out = -32512.
3. Scenario 1 with mmu_en low for 3 cycles between cycle 1 and cycle 2 -> same results 19, 22, 43, 50; busy stays 1 during the gap.
4. Scenario 1 run to completion, then a new start with A=identity, B=[9,-1;2,3] -> c_valid drops on the start edge, then returns with 9, -1, 2, 3.
5. rst_n pulsed low after cycle 1 -> c_valid=0, busy=0, c_out=0 immediately. A fresh sequence then gives correct results.
6. After scenario 1, mmu_cycle 4..7 with mmu_en=1 for 4 cycles -> results and c_valid unchanged.
